// File: rtl/outbuf_wr_sched.sv
// outbuf_wr_sched: write-side scheduler for the multi-block image output buffer.
// Splits a valid/ready RGB pixel stream across NUMBER_OF_BLOCKS buffer blocks,
// driving one-hot write enables plus a shared address and data bus.
// Optional blanking of all blocks is enabled by defining OUTBUF_CLEAR_EN.
module outbuf_wr_sched #(
  parameter int unsigned DATA_WIDTH       = 24,
  parameter int unsigned ADDR_WIDTH       = 11,
  parameter int unsigned MEMORY_WIDTH     = 2048,
  parameter int unsigned NUMBER_OF_BLOCKS = 3
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [DATA_WIDTH-1:0]       PIX_DATA,
  input  logic                        PIX_VALID,
  input  logic                        PIX_SOF,
  output logic                        PIX_READY,
  input  logic                        HOLD,
  input  logic                        CLEAR_REQ,
  output logic [NUMBER_OF_BLOCKS-1:0] WR_ENA,
  output logic [ADDR_WIDTH-1:0]       WR_ADDR,
  output logic [DATA_WIDTH-1:0]       WR_DATA,
  output logic [1:0]                  CUR_BLOCK,
  output logic                        BUSY,
  output logic                        FRAME_DONE,
  output logic                        FRAME_ERR
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEMORY_WIDTH - 1);
  localparam logic [1:0]            BLK_LAST  = 2'(NUMBER_OF_BLOCKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
`ifdef OUTBUF_CLEAR_EN
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
`else
    ST_DONE  = 2'd2
`endif
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [1:0]                  blk_q, blk_d;
  logic [NUMBER_OF_BLOCKS-1:0] wr_ena_q, wr_ena_d;
  logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]       wr_data_q, wr_data_d;
  logic [1:0]                  cur_blk_q, cur_blk_d;
  logic                        frame_err_q, frame_err_d;
`ifdef OUTBUF_CLEAR_EN
  logic                        clr_last_q, clr_last_d;
`else
  logic                        unused_clear_req;
  assign unused_clear_req = CLEAR_REQ;
`endif

  logic                        pix_ready_c;
  logic                        accept;
  logic                        issue;
  logic [1:0]                  wb;
  logic [ADDR_WIDTH-1:0]       wa;
  logic                        wa_last;
  logic                        last_beat;
  logic [NUMBER_OF_BLOCKS-1:0] ena_onehot;

  // Ready is a pure decode of state, stall and (optionally) clear request.
  always_comb begin
    pix_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pix_ready_c = !HOLD;
`ifdef OUTBUF_CLEAR_EN
        if (CLEAR_REQ) pix_ready_c = 1'b0;
`endif
      end
      ST_WRITE: pix_ready_c = !HOLD;
      default:  pix_ready_c = 1'b0;
    endcase
    if (RESET) pix_ready_c = 1'b0;
  end

  assign PIX_READY = pix_ready_c;
  assign accept    = PIX_VALID && pix_ready_c;

  // A SOF beat always lands at block 0, address 0; otherwise at the running position.
  assign wb         = PIX_SOF ? 2'd0 : blk_q;
  assign wa         = PIX_SOF ? '0 : addr_q;
  assign wa_last    = (wa == ADDR_LAST);
  assign last_beat  = wa_last && (wb == BLK_LAST);
  assign ena_onehot = NUMBER_OF_BLOCKS'(1) << wb;

  // Next-state, position counters and registered write-port values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    blk_d       = blk_q;
    wr_ena_d    = '0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cur_blk_d   = cur_blk_q;
    frame_err_d = 1'b0;
    issue       = 1'b0;
`ifdef OUTBUF_CLEAR_EN
    clr_last_d  = clr_last_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef OUTBUF_CLEAR_EN
        if (CLEAR_REQ) begin
          state_d    = ST_CLEAR;
          addr_d     = '0;
          clr_last_d = 1'b0;
        end else
`endif
        if (accept && PIX_SOF) begin
          issue = 1'b1;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          issue       = 1'b1;
          frame_err_d = PIX_SOF;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
`ifdef OUTBUF_CLEAR_EN
      ST_CLEAR: begin
        // Extra cycle after the last address keeps BUSY up while that write lands.
        if (clr_last_q) begin
          state_d = ST_IDLE;
        end else begin
          wr_ena_d  = '1;
          wr_addr_d = addr_q;
          wr_data_d = '0;
          if (addr_q == ADDR_LAST) clr_last_d = 1'b1;
          else                     addr_d     = addr_q + ADDR_WIDTH'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      wr_ena_d  = ena_onehot;
      wr_addr_d = wa;
      wr_data_d = PIX_DATA;
      cur_blk_d = wb;
      if (wa_last) begin
        addr_d = '0;
        blk_d  = wb + 2'd1;
      end else begin
        addr_d = wa + ADDR_WIDTH'(1);
        blk_d  = wb;
      end
      state_d = last_beat ? ST_DONE : ST_WRITE;
    end

    if (state_d == ST_IDLE) begin
      addr_d    = '0;
      blk_d     = '0;
      cur_blk_d = '0;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      blk_q       <= '0;
      wr_ena_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cur_blk_q   <= '0;
      frame_err_q <= 1'b0;
`ifdef OUTBUF_CLEAR_EN
      clr_last_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      blk_q       <= blk_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cur_blk_q   <= cur_blk_d;
      frame_err_q <= frame_err_d;
`ifdef OUTBUF_CLEAR_EN
      clr_last_q  <= clr_last_d;
`endif
    end
  end

  assign WR_ENA     = wr_ena_q;
  assign WR_ADDR    = wr_addr_q;
  assign WR_DATA    = wr_data_q;
  assign CUR_BLOCK  = cur_blk_q;
  assign FRAME_ERR  = frame_err_q;
  assign FRAME_DONE = (state_q == ST_DONE);
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_outbuf_wr_sched.sv
// Testbench for outbuf_wr_sched (default build, clear feature disabled).
module tb_outbuf_wr_sched;

  localparam int DW = 24;
  localparam int AW = 11;
  localparam int MW = 2048;
  localparam int NB = 3;
  localparam int FRAME = MW * NB;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [DW-1:0] PIX_DATA = '0;
  logic          PIX_VALID = 1'b0;
  logic          PIX_SOF = 1'b0;
  logic          PIX_READY;
  logic          HOLD = 1'b0;
  logic          CLEAR_REQ = 1'b0;
  logic [NB-1:0] WR_ENA;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic [1:0]    CUR_BLOCK;
  logic          BUSY;
  logic          FRAME_DONE;
  logic          FRAME_ERR;

  outbuf_wr_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_WIDTH(MW), .NUMBER_OF_BLOCKS(NB)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
    .PIX_SOF(PIX_SOF), .PIX_READY(PIX_READY), .HOLD(HOLD), .CLEAR_REQ(CLEAR_REQ),
    .WR_ENA(WR_ENA), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .CUR_BLOCK(CUR_BLOCK),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NB-1:0] ena;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    blk;
    logic          done;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  int n_cmp = 0;
  int n_err = 0;
  int seen_dones = 0;
  int seen_errs = 0;
  int exp_dones = 0;
  int exp_errs = 0;
  bit mon_en = 1'b0;

  // Reference model of the write position.
  bit in_frame = 1'b0;
  bit done_pending = 1'b0;
  int m_blk = 0;
  int m_addr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_accept();
    exp_t e;
    logic err;
    err = 1'b0;
    if (PIX_SOF) begin
      err = in_frame;
      if (in_frame) exp_errs++;
      in_frame = 1'b1;
      m_blk = 0;
      m_addr = 0;
    end
    if (in_frame) begin
      e.ena = '0;
      e.ena[m_blk] = 1'b1;
      e.addr = AW'(m_addr);
      e.data = PIX_DATA;
      e.blk = 2'(m_blk);
      e.done = (m_blk == NB - 1) && (m_addr == MW - 1);
      e.err = err;
      sb.push_back(e);
      m_addr++;
      if (m_addr == MW) begin
        m_addr = 0;
        m_blk++;
      end
      if (e.done) begin
        in_frame = 1'b0;
        done_pending = 1'b1;
        exp_dones++;
      end
    end
  endtask

  // One clock cycle of stimulus; ready and busy are checked against the model.
  task automatic beat(input logic v, input logic sof, input logic hold, output logic acc);
    logic dp;
    logic exp_rdy;
    @(posedge CLK); #1;
    PIX_VALID = v;
    PIX_SOF = sof;
    HOLD = hold;
    PIX_DATA = DW'($urandom);
    dp = done_pending;
    done_pending = 1'b0;
    exp_rdy = !hold && !dp;
    #1;
    check("pix_ready", 64'(PIX_READY), 64'(exp_rdy));
    check("busy", 64'(BUSY), 64'(in_frame || dp));
    acc = PIX_VALID && PIX_READY;
    if (acc) model_accept();
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    PIX_VALID = 1'b0;
    PIX_SOF = 1'b0;
    HOLD = 1'b0;
    @(posedge CLK); #1;
    mon_en = 1'b1;
    in_frame = 1'b0;
    done_pending = 1'b0;
    check("rst_ready", 64'(PIX_READY), 64'(0));
    check("rst_wr_ena", 64'(WR_ENA), 64'(0));
    check("rst_wr_addr", 64'(WR_ADDR), 64'(0));
    check("rst_wr_data", 64'(WR_DATA), 64'(0));
    check("rst_cur_block", 64'(CUR_BLOCK), 64'(0));
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_done_err", 64'({FRAME_DONE, FRAME_ERR}), 64'(0));
    check("rst_sb_empty", 64'(sb.size()), 64'(0));
    RESET = 1'b0;
    #1;
    check("post_rst_ready", 64'(PIX_READY), 64'(1));
  endtask

  // Scoreboard: every write must match the oldest expected write.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (FRAME_DONE) seen_dones++;
      if (FRAME_ERR) seen_errs++;
      if (WR_ENA !== '0) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 64'(WR_ENA), 64'(0));
        end else begin
          me = sb.pop_front();
          check("wr_ena", 64'(WR_ENA), 64'(me.ena));
          check("wr_addr", 64'(WR_ADDR), 64'(me.addr));
          check("wr_data", 64'(WR_DATA), 64'(me.data));
          check("cur_block", 64'(CUR_BLOCK), 64'(me.blk));
          check("frame_done", 64'(FRAME_DONE), 64'(me.done));
          check("frame_err", 64'(FRAME_ERR), 64'(me.err));
        end
      end else begin
        check("no_write_done_err", 64'({FRAME_DONE, FRAME_ERR}), 64'(0));
      end
    end
  end

  initial begin
    logic acc;
    int acc_cnt;
    int hold_cnt;

    do_reset();

    // Pre-frame junk: accepted but discarded.
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b0, 1'b0, acc);
      if (acc) acc_cnt++;
    end
    check("junk_accepted", 64'(acc_cnt), 64'(5));

    // Full contiguous frame.
    acc_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      beat(1'b1, (i == 0), 1'b0, acc);
      if (acc) acc_cnt++;
    end
    check("full_frame_len", 64'(acc_cnt), 64'(FRAME));
    beat(1'b0, 1'b0, 1'b0, acc);
    check("dones_after_full", 64'(exp_dones), 64'(1));

    // Backpressure: random valid gaps and a 10-cycle hold near the block boundary.
    acc_cnt = 0;
    hold_cnt = 0;
    for (int c = 0; c < 20000 && acc_cnt < FRAME; c++) begin
      logic h;
      h = (acc_cnt >= 2045) && (hold_cnt < 10);
      if (h) hold_cnt++;
      beat(($urandom_range(0, 3) != 0), (acc_cnt == 0), h, acc);
      if (acc) acc_cnt++;
    end
    check("bp_frame_len", 64'(acc_cnt), 64'(FRAME));
    beat(1'b0, 1'b0, 1'b0, acc);

    // Early SOF at beat 3000, then that restarted frame runs to completion.
    acc_cnt = 0;
    for (int i = 0; i < 3000 + FRAME; i++) begin
      beat(1'b1, (i == 0) || (i == 3000), 1'b0, acc);
      if (acc) acc_cnt++;
    end
    check("early_sof_len", 64'(acc_cnt), 64'(3000 + FRAME));
    beat(1'b0, 1'b0, 1'b0, acc);

    // Reset mid-frame after 1500 beats, then a clean frame.
    for (int i = 0; i < 1500; i++) begin
      beat(1'b1, (i == 0), 1'b0, acc);
    end
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      beat(1'b1, (i == 0), 1'b0, acc);
      if (acc) acc_cnt++;
    end
    check("post_reset_frame_len", 64'(acc_cnt), 64'(FRAME));
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 1'b0, acc);

    check("sb_drained", 64'(sb.size()), 64'(0));
    check("done_count", 64'(seen_dones), 64'(4));
    check("err_count", 64'(seen_errs), 64'(1));
    check("model_done_count", 64'(seen_dones), 64'(exp_dones));
    check("model_err_count", 64'(seen_errs), 64'(exp_errs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
